// File: rtl/lstm_step_sequencer_pkg.sv
// Shared types and widths for the LSTM step sequencer: FSM states and index/step counter widths.
package lstm_step_sequencer_pkg;

    localparam int INPUT_SIZE_DEF   = 26;
    localparam int ALL_CELL_NUM_DEF = 30;
    localparam int UNITS_NUM_DEF    = 5;
    localparam int D_WL_DEF         = 22;
    localparam int SEQ_LEN_DEF      = 16;

    localparam int IDX_W  = $clog2(INPUT_SIZE_DEF + ALL_CELL_NUM_DEF);
    localparam int STEP_W = $clog2(SEQ_LEN_DEF);
    localparam int HSEL_W = $clog2(ALL_CELL_NUM_DEF);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FEED_X,
        ST_FEED_H,
        ST_WAIT,
        ST_UPDATE
    } state_t;

endpackage

// File: rtl/lstm_state_buf.sv
// Recurrent state storage: committed h/c registers, capture registers with "got" flags, indexed h read.
// Capture only while enabled; commit copies captured values into the committed state in one cycle.
module lstm_state_buf
    import lstm_step_sequencer_pkg::*;
#(
    parameter int ALL_CELL_NUM = ALL_CELL_NUM_DEF,
    parameter int UNITS_NUM    = UNITS_NUM_DEF,
    parameter int D_WL         = D_WL_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    input  logic                        cap_en,
    input  logic                        commit,
    input  logic [UNITS_NUM*D_WL-1:0]   c_o,
    input  logic                        c_o_valid,
    input  logic [ALL_CELL_NUM*D_WL-1:0] h_all,
    input  logic                        h_all_valid,
    input  logic [HSEL_W-1:0]           rd_sel,
    output logic [D_WL-1:0]             rd_dat,
    output logic [UNITS_NUM*D_WL-1:0]   c_reg,
    output logic                        both_ready
);

    logic [ALL_CELL_NUM*D_WL-1:0] h_reg;
    logic [ALL_CELL_NUM*D_WL-1:0] h_cap;
    logic [UNITS_NUM*D_WL-1:0]    c_cap;
    logic                         got_c;
    logic                         got_h;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_reg <= '0;
            h_cap <= '0;
            c_reg <= '0;
            c_cap <= '0;
            got_c <= 1'b0;
            got_h <= 1'b0;
        end else if (clear) begin
            h_reg <= '0;
            h_cap <= '0;
            c_reg <= '0;
            c_cap <= '0;
            got_c <= 1'b0;
            got_h <= 1'b0;
        end else begin
            if (cap_en && c_o_valid) begin
                c_cap <= c_o;
                got_c <= 1'b1;
            end
            if (cap_en && h_all_valid) begin
                h_cap <= h_all;
                got_h <= 1'b1;
            end
            if (commit) begin
                h_reg <= h_cap;
                c_reg <= c_cap;
                got_c <= 1'b0;
                got_h <= 1'b0;
            end
        end
    end

    // Counting a pulse arriving this cycle lets the FSM leave WAIT right after the last capture.
    assign both_ready = cap_en && (got_c || c_o_valid) && (got_h || h_all_valid);
    assign rd_dat     = h_reg[rd_sel*D_WL +: D_WL];

endmodule

// File: rtl/lstm_step_sequencer.sv
// Streams INPUT_SIZE external words then the stored hidden vector per timestep; closes the recurrent loop.
// x lags an x_in accept by one cycle; FEED_H is gapless; x_in_ready only in FEED_X.
module lstm_step_sequencer
    import lstm_step_sequencer_pkg::*;
#(
    parameter int INPUT_SIZE   = INPUT_SIZE_DEF,
    parameter int ALL_CELL_NUM = ALL_CELL_NUM_DEF,
    parameter int UNITS_NUM    = UNITS_NUM_DEF,
    parameter int D_WL         = D_WL_DEF,
    parameter int SEQ_LEN      = SEQ_LEN_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [D_WL-1:0]              x_in,
    input  logic                         x_in_valid,
    output logic                         x_in_ready,
    output logic [D_WL-1:0]              x,
    output logic                         lstm_in_valid,
    output logic [IDX_W-1:0]             elem_idx,
    output logic [UNITS_NUM*D_WL-1:0]    pre_c,
    input  logic [UNITS_NUM*D_WL-1:0]    c_o,
    input  logic                         c_o_valid,
    input  logic [ALL_CELL_NUM*D_WL-1:0] h_all,
    input  logic                         h_all_valid,
    output logic [STEP_W-1:0]            step_cnt,
    output logic                         busy,
    output logic                         seq_done,
    output logic                         protocol_err
);

    localparam logic [IDX_W-1:0]  LAST_X_IDX = IDX_W'(INPUT_SIZE - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(INPUT_SIZE + ALL_CELL_NUM - 1);
    localparam logic [STEP_W-1:0] LAST_STEP  = STEP_W'(SEQ_LEN - 1);

    state_t            state_q;
    state_t            state_d;
    logic [IDX_W-1:0]  idx_q;
    logic [HSEL_W-1:0] rd_sel;
    logic [D_WL-1:0]   h_word;
    logic              both_ready;
    logic              seq_clear;
    logic              last_step;

    assign seq_clear = (state_q == ST_IDLE) && start;
    assign last_step = (step_cnt == LAST_STEP);
    assign rd_sel    = HSEL_W'(idx_q - IDX_W'(INPUT_SIZE));

    lstm_state_buf #(
        .ALL_CELL_NUM (ALL_CELL_NUM),
        .UNITS_NUM    (UNITS_NUM),
        .D_WL         (D_WL)
    ) u_state_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (seq_clear),
        .cap_en      (state_q == ST_WAIT),
        .commit      (state_q == ST_UPDATE),
        .c_o         (c_o),
        .c_o_valid   (c_o_valid),
        .h_all       (h_all),
        .h_all_valid (h_all_valid),
        .rd_sel      (rd_sel),
        .rd_dat      (h_word),
        .c_reg       (pre_c),
        .both_ready  (both_ready)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        x_in_ready = 1'b0;
        busy       = 1'b1;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_d = ST_FEED_X;
            end
            ST_FEED_X: begin
                x_in_ready = 1'b1;
                if (x_in_valid && idx_q == LAST_X_IDX) state_d = ST_FEED_H;
            end
            ST_FEED_H: begin
                if (idx_q == LAST_IDX) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (both_ready) state_d = ST_UPDATE;
            end
            ST_UPDATE: begin
                state_d = last_step ? ST_IDLE : ST_FEED_X;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q         <= '0;
            x             <= '0;
            elem_idx      <= '0;
            lstm_in_valid <= 1'b0;
            step_cnt      <= '0;
            seq_done      <= 1'b0;
            protocol_err  <= 1'b0;
        end else begin
            seq_done      <= 1'b0;
            lstm_in_valid <= 1'b0;
            // A stray pulse in the start cycle still flags, so the set wins over the clear.
            if (seq_clear) protocol_err <= 1'b0;
            if ((c_o_valid || h_all_valid) && state_q != ST_WAIT) protocol_err <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        idx_q    <= '0;
                        step_cnt <= '0;
                    end
                end
                ST_FEED_X: begin
                    if (x_in_valid) begin
                        x             <= x_in;
                        elem_idx      <= idx_q;
                        lstm_in_valid <= 1'b1;
                        idx_q         <= idx_q + 1'b1;
                    end
                end
                ST_FEED_H: begin
                    x             <= h_word;
                    elem_idx      <= idx_q;
                    lstm_in_valid <= 1'b1;
                    if (idx_q != LAST_IDX) idx_q <= idx_q + 1'b1;
                end
                ST_UPDATE: begin
                    idx_q <= '0;
                    if (last_step) begin
                        seq_done <= 1'b1;
                        step_cnt <= '0;
                    end else begin
                        step_cnt <= step_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lstm_step_sequencer.sv
// Randomized bench for lstm_step_sequencer against a step-level model of the stream and recurrent state.
module tb_lstm_step_sequencer;

    localparam int IS = 26;
    localparam int AC = 30;
    localparam int UN = 5;
    localparam int DW = 22;
    localparam int SL = 16;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic [DW-1:0]       x_in;
    logic                x_in_valid;
    logic                x_in_ready;
    logic [DW-1:0]       x;
    logic                lstm_in_valid;
    logic [5:0]          elem_idx;
    logic [UN*DW-1:0]    pre_c;
    logic [UN*DW-1:0]    c_o;
    logic                c_o_valid;
    logic [AC*DW-1:0]    h_all;
    logic                h_all_valid;
    logic [3:0]          step_cnt;
    logic                busy;
    logic                seq_done;
    logic                protocol_err;

    lstm_step_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .x_in          (x_in),
        .x_in_valid    (x_in_valid),
        .x_in_ready    (x_in_ready),
        .x             (x),
        .lstm_in_valid (lstm_in_valid),
        .elem_idx      (elem_idx),
        .pre_c         (pre_c),
        .c_o           (c_o),
        .c_o_valid     (c_o_valid),
        .h_all         (h_all),
        .h_all_valid   (h_all_valid),
        .step_cnt      (step_cnt),
        .busy          (busy),
        .seq_done      (seq_done),
        .protocol_err  (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    // Model: what the layer should see as recurrent state, in plain arrays.
    logic [DW-1:0] h_model [AC];
    logic [DW-1:0] c_model [UN];
    logic          err_model;

    always @(negedge clk) if (seq_done) done_cnt++;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [UN*DW-1:0] c_flat();
        logic [UN*DW-1:0] v;
        for (int u = 0; u < UN; u++) v[u*DW +: DW] = c_model[u];
        return v;
    endfunction

    task automatic zero_model();
        for (int k = 0; k < AC; k++) h_model[k] = '0;
        for (int u = 0; u < UN; u++) c_model[u] = '0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        zero_model();
        err_model = 1'b0;
        check("start_ready", x_in_ready, 1'b1);
        check("start_busy", busy, 1'b1);
        check("start_step", step_cnt, 0);
        check("start_perr", protocol_err, err_model);
        check("start_prec", pre_c, c_flat());
    endtask

    // gap_mode: 0 back-to-back, 1 alternating, 2 random. wait_mode: 0 h first, 1 c first, 2 same cycle.
    task automatic run_step(input int s, input int gap_mode, input int wait_mode, input bit det,
                            input bit stray, input bit start_in_gap, input int abort_j);
        logic [DW-1:0]    v;
        logic [DW-1:0]    newh [AC];
        logic [DW-1:0]    newc [UN];
        logic [AC*DW-1:0] hv;
        logic [UN*DW-1:0] cv;
        bit               gap;
        int               g;

        check("step_cnt", step_cnt, s);
        check("prec_step", pre_c, c_flat());

        for (int i = 0; i < IS; i++) begin
            gap = 1'b0;
            if (gap_mode == 1) gap = (i > 0);
            if (gap_mode == 2) gap = ($urandom_range(0, 2) == 0);
            if (start_in_gap && i == 13) gap = 1'b1;
            if (gap) begin
                x_in_valid = 1'b0;
                if (start_in_gap && i == 13) start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                check("gap_vld", lstm_in_valid, 1'b0);
            end
            v = det ? DW'(i + 1) : DW'($urandom);
            x_in       = v;
            x_in_valid = 1'b1;
            check("x_ready", x_in_ready, 1'b1);
            @(negedge clk);
            check("x_vld", lstm_in_valid, 1'b1);
            check("x_dat", x, v);
            check("x_idx", elem_idx, i);
        end
        x_in_valid = 1'b0;

        for (int j = 0; j < AC; j++) begin
            @(negedge clk);
            if (stray && j == 11) begin
                c_o_valid = 1'b0;
                err_model = 1'b1;
                check("stray_perr", protocol_err, 1'b1);
            end
            check("h_vld", lstm_in_valid, 1'b1);
            check("h_dat", x, h_model[j]);
            check("h_idx", elem_idx, IS + j);
            if (j == 0) check("h_ready", x_in_ready, 1'b0);
            if (stray && j == 10) begin
                c_o       = UN*DW'($urandom);
                c_o_valid = 1'b1;
            end
            if (j == abort_j) return;
        end

        for (int k = 0; k < AC; k++) newh[k] = det ? DW'(k + 100) : DW'($urandom);
        for (int u = 0; u < UN; u++) newc[u] = det ? DW'(7) : DW'($urandom);
        for (int k = 0; k < AC; k++) hv[k*DW +: DW] = newh[k];
        for (int u = 0; u < UN; u++) cv[u*DW +: DW] = newc[u];

        repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            check("wait_vld", lstm_in_valid, 1'b0);
            check("wait_busy", busy, 1'b1);
        end

        g = det ? 3 : $urandom_range(1, 4);
        h_all = hv;
        c_o   = cv;
        if (wait_mode == 2) begin
            h_all_valid = 1'b1;
            c_o_valid   = 1'b1;
            @(negedge clk);
            h_all_valid = 1'b0;
            c_o_valid   = 1'b0;
        end else begin
            if (wait_mode == 0) h_all_valid = 1'b1; else c_o_valid = 1'b1;
            @(negedge clk);
            h_all_valid = 1'b0;
            c_o_valid   = 1'b0;
            repeat (g - 1) begin
                @(negedge clk);
                check("half_ready", x_in_ready, 1'b0);
                check("half_step", step_cnt, s);
            end
            if (wait_mode == 0) c_o_valid = 1'b1; else h_all_valid = 1'b1;
            @(negedge clk);
            h_all_valid = 1'b0;
            c_o_valid   = 1'b0;
        end
        h_all = '0;
        c_o   = '0;

        check("upd_ready", x_in_ready, 1'b0);
        check("upd_busy", busy, 1'b1);
        check("upd_step", step_cnt, s);
        for (int k = 0; k < AC; k++) h_model[k] = newh[k];
        for (int u = 0; u < UN; u++) c_model[u] = newc[u];

        @(negedge clk);
        check("perr_step", protocol_err, err_model);
        if (s == SL - 1) begin
            check("done_pulse", seq_done, 1'b1);
            check("done_busy", busy, 1'b0);
            check("done_step", step_cnt, 0);
            @(negedge clk);
            check("done_fall", seq_done, 1'b0);
        end else begin
            check("next_ready", x_in_ready, 1'b1);
            check("next_prec", pre_c, c_flat());
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        x_in        = '0;
        x_in_valid  = 1'b0;
        c_o         = '0;
        c_o_valid   = 1'b0;
        h_all       = '0;
        h_all_valid = 1'b0;
        zero_model();
        err_model   = 1'b0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_ready", x_in_ready, 1'b0);
        check("rst_prec", pre_c, 0);
        check("rst_vld", lstm_in_valid, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 1'b0);
        check("idle_ready", x_in_ready, 1'b0);

        do_start();
        for (int s = 0; s < SL; s++) begin
            run_step(s,
                     (s == 0) ? 0 : (s == 1) ? 1 : 2,
                     (s == 0) ? 0 : (s == 2) ? 2 : (s == 5) ? 1 : $urandom_range(0, 2),
                     s == 0, s == 4, s == 3, -1);
        end
        check("done_count", done_cnt, 1);
        check("end_busy", busy, 1'b0);
        check("end_step", step_cnt, 0);
        check("end_perr", protocol_err, 1'b1);

        do_start();
        run_step(0, 2, 0, 1'b0, 1'b0, 1'b0, 5);
        rst_n = 1'b0;
        #1;
        check("arst_x", x, 0);
        check("arst_idx", elem_idx, 0);
        check("arst_vld", lstm_in_valid, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_ready", x_in_ready, 1'b0);
        check("arst_step", step_cnt, 0);
        check("arst_prec", pre_c, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_start();
        run_step(0, 2, 1, 1'b0, 1'b0, 1'b0, -1);
        run_step(1, 0, 2, 1'b0, 1'b0, 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lstm_step_sequencer.md
Name: lstm_step_sequencer

Overview:
Drives the serial input side of one LSTM layer slice and closes the recurrent loop.
- Per timestep, streams INPUT_SIZE external samples, then ALL_CELL_NUM stored hidden-state words, on x/lstm_in_valid, with a matching weight-element index.
- Holds pre_c for its slice.
- Captures the slice's c_o and the full assembled hidden vector at step end.
- Counts timesteps up to SEQ_LEN.

Parameters:
INPUT_SIZE, 26, external feature words per timestep
ALL_CELL_NUM, 30, hidden-state words fed back per timestep (all slices)
UNITS_NUM, 5, cells in the driven slice (width of pre_c/c_o)
D_WL, 22, data word width (fixed point, FL fractional bits, not interpreted here)
SEQ_LEN, 16, timesteps per sequence

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begins a sequence when idle
x_in  in  D_WL  external feature word
x_in_valid  in  1  x_in valid
x_in_ready  out  1  block accepts x_in this cycle
x  out  D_WL  serial word to LSTM layer
lstm_in_valid  out  1  x valid
elem_idx  out  $clog2(INPUT_SIZE+ALL_CELL_NUM)  element index of x, weight-ROM address
pre_c  out  UNITS_NUM*D_WL  previous cell state of the slice
c_o  in  UNITS_NUM*D_WL  new cell state from the layer
c_o_valid  in  1  c_o valid pulse
h_all  in  ALL_CELL_NUM*D_WL  assembled hidden vector from all slices
h_all_valid  in  1  h_all valid pulse
step_cnt  out  $clog2(SEQ_LEN)  current timestep
busy  out  1  sequence in progress
seq_done  out  1  single-cycle pulse after last step's state update
protocol_err  out  1  sticky; c_o_valid/h_all_valid seen outside WAIT

Behaviour:
Reset values (async, immediate):
- x, elem_idx, pre_c, step_cnt: 0.
- lstm_in_valid, x_in_ready, busy, seq_done, protocol_err: 0.
- Internal h_reg and c_reg: 0.
- FSM: IDLE.

FSM states: IDLE, FEED_X, FEED_H, WAIT, UPDATE.
- IDLE:
  - start=1 clears h_reg, c_reg, step_cnt and idx, then goes to FEED_X.
  - start in any other state is ignored.
- FEED_X:
  - x_in_ready=1 combinationally.
  - Each accepted beat (x_in_valid & x_in_ready) registers x<=x_in, elem_idx<=idx and lstm_in_valid<=1 for the next cycle.
  - Cycles with no beat give lstm_in_valid=0 next cycle; the layer tolerates gaps.
  - After beat INPUT_SIZE-1, go to FEED_H with idx=INPUT_SIZE.
- FEED_H:
  - x_in_ready=0.
  - One word per cycle, no gaps: x<=h_reg[idx-INPUT_SIZE], elem_idx<=idx, lstm_in_valid<=1.
  - After idx=INPUT_SIZE+ALL_CELL_NUM-1, go to WAIT.
- WAIT:
  - Latches c_o on c_o_valid and h_all on h_all_valid, with independent "got" flags.
  - The two pulses may arrive in either order or the same cycle.
  - When both flags are set, go to UPDATE.
- UPDATE (one cycle):
  - c_reg<=captured c_o, h_reg<=captured h_all; flags cleared, idx<=0.
  - If step_cnt==SEQ_LEN-1: seq_done=1 next cycle, step_cnt<=0, go to IDLE.
  - Else: step_cnt<=step_cnt+1, go to FEED_X.

Timing and output rules:
- pre_c = c_reg, constant for the whole step; a sequence starts from 0.
- Latency: x/lstm_in_valid lag the x_in accept by exactly 1 cycle. elem_idx is always aligned with x.
- busy=1 in every state except IDLE. busy falls in the same cycle seq_done rises.
- Valid pulses outside WAIT are dropped and set protocol_err. protocol_err clears only on reset or a new start.
- Reset mid-operation returns to IDLE with all state zeroed. A partial step is discarded.
- Widths: no arithmetic on data words. idx and step_cnt wrap only by explicit reload, never by overflow.

Decomposition:
- Shared package: FSM state enum and idx/step width localparams (clog2 values).
- One natural sub-module: lstm_state_buf, the h_reg/c_reg storage with capture flags, clear, and indexed h read port.
- The FSM and stream datapath stay in the top.

Test Plan:
- Reset then idle: busy=0, x_in_ready=0, pre_c=0; start with defaults → FEED_X, x_in_ready=1. Feed x_in=1..26 back-to-back → lstm_in_valid for 56 consecutive cycles. x=1..26 at elem_idx 0..25, then 30 zero words at elem_idx 26..55.
- x_in_valid toggling 1/0 in FEED_X → lstm_in_valid gaps mirror the input. elem_idx still increments only on accepted beats. The FEED_H burst stays gapless.
- Step 0 end: h_all_valid first with word k=k+100, c_o_valid 3 cycles later with c_o words=7 → step_cnt=1, pre_c all words 7. Step 1 FEED_H emits 100..129.
- Both valid pulses in the same WAIT cycle → UPDATE next cycle. A c_o_valid pulse during FEED_H → protocol_err=1, state unchanged.
- Full sequence of 16 steps → seq_done pulses exactly once, busy=0, step_cnt=0. A start during busy has no effect.
- rst_n low mid-FEED_H → all outputs 0 immediately. A following start runs from step 0 with zero h/c.
